// File: rtl/activation_pipeline.sv
// Multi-lane activation stage: two registered stages with valid/ready on both
// sides, shadowed runtime configuration and a saturating zeroed-lane counter.
module activation_pipeline #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LANES  = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_we,
  input  logic [1:0]                cfg_mode,
  input  logic [DATA_W-1:0]         cfg_thr,
  input  logic [DATA_W-1:0]         cfg_cap,
  input  logic [$clog2(DATA_W)-1:0] cfg_shift,
  output logic                      cfg_pending,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATA_W-1:0]   in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*DATA_W-1:0]   out_data,
  output logic                      busy,
  input  logic                      cnt_clr,
  output logic [CNT_W-1:0]          zero_cnt
);

  localparam int unsigned SH_W  = $clog2(DATA_W);
  localparam int unsigned BUS_W = LANES * DATA_W;
  localparam int unsigned PC_W  = $clog2(LANES + 1);
  localparam int unsigned SUM_W = CNT_W + PC_W;

  localparam logic [DATA_W-1:0] THR_RST   = DATA_W'(10);
  localparam logic [DATA_W-1:0] CAP_RST   = '1;
  localparam logic [SH_W-1:0]   SHIFT_RST = SH_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'd0,
    MODE_THRESH = 2'd1,
    MODE_CLAMP  = 2'd2,
    MODE_LEAKY  = 2'd3
  } mode_e;

  // Active and shadow configuration
  mode_e             act_mode, sh_mode;
  logic [DATA_W-1:0] act_thr, sh_thr;
  logic [DATA_W-1:0] act_cap, sh_cap;
  logic [SH_W-1:0]   act_shift, sh_shift;

  // Stage 1 state
  logic              s1_valid;
  logic [BUS_W-1:0]  s1_data;
  logic [LANES-1:0]  s1_lt;
  logic [LANES-1:0]  s1_gt;
  mode_e             s1_mode;

  // Stage 2 state (out_data is the stage-2 result register)
  logic              s2_valid;
  logic [LANES-1:0]  s2_zero;

  logic              s2_adv_c;
  logic              s1_adv_c;
  logic              accept_c;
  logic              apply_c;
  logic              out_hs_c;
  logic [LANES-1:0]  lt_c;
  logic [LANES-1:0]  gt_c;
  logic [BUS_W-1:0]  res_c;
  logic [LANES-1:0]  zero_c;
  logic [PC_W-1:0]   zcount_c;
  logic [SUM_W-1:0]  cnt_sum_c;

  // Handshake control; in_ready follows out_ready combinationally
  assign busy      = s1_valid || s2_valid;
  assign out_valid = s2_valid;
  assign s2_adv_c  = !s2_valid || out_ready;
  assign s1_adv_c  = s1_valid && s2_adv_c;
  assign in_ready  = !cfg_pending && (!s1_valid || s1_adv_c);
  assign accept_c  = in_valid && in_ready;
  assign apply_c   = cfg_pending && !busy;
  assign out_hs_c  = s2_valid && out_ready;

  // Shadow captures every write; active only updates once the pipe is empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_mode    <= MODE_THRESH;
      act_thr     <= THR_RST;
      act_cap     <= CAP_RST;
      act_shift   <= SHIFT_RST;
      sh_mode     <= MODE_THRESH;
      sh_thr      <= THR_RST;
      sh_cap      <= CAP_RST;
      sh_shift    <= SHIFT_RST;
      cfg_pending <= 1'b0;
    end else begin
      if (apply_c) begin
        act_mode  <= sh_mode;
        act_thr   <= sh_thr;
        act_cap   <= sh_cap;
        act_shift <= sh_shift;
      end
      if (cfg_we) begin
        sh_mode     <= mode_e'(cfg_mode);
        sh_thr      <= cfg_thr;
        sh_cap      <= cfg_cap;
        sh_shift    <= cfg_shift;
        cfg_pending <= 1'b1;
      end else if (apply_c) begin
        cfg_pending <= 1'b0;
      end
    end
  end

  // Per-lane compare flags against the active config
  always_comb begin
    lt_c = '0;
    gt_c = '0;
    for (int i = 0; i < LANES; i++) begin
      lt_c[i] = in_data[i*DATA_W +: DATA_W] < act_thr;
      gt_c[i] = in_data[i*DATA_W +: DATA_W] > act_cap;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_lt    <= '0;
      s1_gt    <= '0;
      s1_mode  <= MODE_THRESH;
    end else if (!s1_valid || s1_adv_c) begin
      s1_valid <= accept_c;
      if (accept_c) begin
        s1_data <= in_data;
        s1_lt   <= lt_c;
        s1_gt   <= gt_c;
        s1_mode <= act_mode;
      end
    end
  end

  // Activation function; cap/shift cannot change while a beat is in flight
  always_comb begin
    res_c  = '0;
    zero_c = '0;
    for (int i = 0; i < LANES; i++) begin
      case (s1_mode)
        MODE_PASS:   res_c[i*DATA_W +: DATA_W] = s1_data[i*DATA_W +: DATA_W];
        MODE_THRESH: res_c[i*DATA_W +: DATA_W] = s1_lt[i] ? '0 : s1_data[i*DATA_W +: DATA_W];
        MODE_CLAMP:  res_c[i*DATA_W +: DATA_W] = s1_lt[i] ? '0 :
                                                 s1_gt[i] ? act_cap : s1_data[i*DATA_W +: DATA_W];
        MODE_LEAKY:  res_c[i*DATA_W +: DATA_W] = s1_lt[i] ? (s1_data[i*DATA_W +: DATA_W] >> act_shift)
                                                          : s1_data[i*DATA_W +: DATA_W];
        default:     res_c[i*DATA_W +: DATA_W] = s1_data[i*DATA_W +: DATA_W];
      endcase
      zero_c[i] = s1_lt[i] && ((s1_mode == MODE_THRESH) || (s1_mode == MODE_CLAMP));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out_data <= '0;
      s2_zero  <= '0;
    end else if (s2_adv_c) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= res_c;
        s2_zero  <= zero_c;
      end
    end
  end

  // Popcount of zeroed lanes and widened sum for saturation
  always_comb begin
    zcount_c = '0;
    for (int i = 0; i < LANES; i++) begin
      zcount_c = zcount_c + PC_W'(s2_zero[i]);
    end
    cnt_sum_c = SUM_W'(zero_cnt) + SUM_W'(zcount_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_cnt <= '0;
    end else if (cnt_clr) begin
      zero_cnt <= '0;
    end else if (out_hs_c) begin
      zero_cnt <= (cnt_sum_c > SUM_W'(CNT_MAX)) ? CNT_MAX : cnt_sum_c[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_activation_pipeline.sv
// Scoreboard bench for activation_pipeline: model results queued at input
// acceptance, compared when the output handshake occurs.
`timescale 1ns/1ps
module tb_activation_pipeline;

  localparam int unsigned DW = 8;
  localparam int unsigned LN = 4;
  localparam int unsigned CW = 4;
  localparam int unsigned BW = DW * LN;
  localparam int         CMAX = 15;

  typedef struct {
    logic [BW-1:0] data;
    int            zc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_mode = 2'd1;
  logic [DW-1:0] cfg_thr = 8'h0A;
  logic [DW-1:0] cfg_cap = 8'hFF;
  logic [2:0]    cfg_shift = 3'd1;
  logic          cfg_pending;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [BW-1:0] out_data;
  logic          busy;
  logic          cnt_clr = 1'b0;
  logic [CW-1:0] zero_cnt;

  int checks = 0;
  int passes = 0;
  int n_acc  = 0;
  int n_del  = 0;
  int exp_cnt = 0;

  exp_t          sb[$];
  exp_t          mon_e;
  logic [BW-1:0] stim[$];
  logic [BW-1:0] mon_last = '0;
  logic [BW-1:0] prev_data = '0;
  logic          prev_stall = 1'b0;
  logic          mon_hs;

  logic [1:0]    m_mode  = 2'd1;
  logic [DW-1:0] m_thr   = 8'h0A;
  logic [DW-1:0] m_cap   = 8'hFF;
  logic [2:0]    m_shift = 3'd1;

  activation_pipeline #(.DATA_W(DW), .LANES(LN), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_mode(cfg_mode), .cfg_thr(cfg_thr), .cfg_cap(cfg_cap),
    .cfg_shift(cfg_shift), .cfg_pending(cfg_pending),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .cnt_clr(cnt_clr), .zero_cnt(zero_cnt)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [BW-1:0] d);
    exp_t e;
    logic [DW-1:0] x, y;
    logic lt;
    e.data = '0;
    e.zc   = 0;
    for (int i = 0; i < int'(LN); i++) begin
      x  = d[i*DW +: DW];
      lt = x < m_thr;
      case (m_mode)
        2'd0:    y = x;
        2'd1:    y = lt ? 8'h00 : x;
        2'd2:    y = lt ? 8'h00 : ((x > m_cap) ? m_cap : x);
        default: y = lt ? (x >> m_shift) : x;
      endcase
      if (lt && (m_mode == 2'd1 || m_mode == 2'd2)) e.zc++;
      e.data[i*DW +: DW] = y;
    end
    return e;
  endfunction

  // Output monitor: counter model, stall hold and scoreboard pop
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_cnt    = 0;
      prev_stall = 1'b0;
    end else begin
      checks++;
      if (zero_cnt !== CW'(exp_cnt)) $display("FAIL zero_cnt_track: got %0d expected %0d", zero_cnt, exp_cnt);
      else passes++;
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== prev_data)
          $display("FAIL stall_hold: got valid=%b data=%h expected valid=1 data=%h", out_valid, out_data, prev_data);
        else passes++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      mon_hs     = (out_valid === 1'b1) && (out_ready === 1'b1);
      mon_e.zc   = 0;
      if (mon_hs) begin
        checks++;
        if (sb.size() == 0) begin
          $display("FAIL unexpected_beat: got %h expected no beat", out_data);
        end else begin
          mon_e = sb.pop_front();
          if (out_data !== mon_e.data) $display("FAIL out_data: got %h expected %h", out_data, mon_e.data);
          else passes++;
        end
        mon_last = out_data;
        n_del++;
      end
      if (cnt_clr) exp_cnt = 0;
      else if (mon_hs) exp_cnt = (exp_cnt + mon_e.zc > CMAX) ? CMAX : exp_cnt + mon_e.zc;
    end
  end

  task automatic send_beats();
    int idx = 0;
    int g = 0;
    if (stim.size() == 0) return;
    in_valid = 1'b1;
    in_data  = stim[0];
    while (idx < int'(stim.size()) && g < 500) begin
      @(negedge clk);
      if (out_valid === 1'b1 && out_ready === 1'b0 && (n_acc - n_del) == 2) begin
        checks++;
        if (in_ready !== 1'b0) $display("FAIL in_ready_full: got %b expected 0", in_ready);
        else passes++;
      end
      if (in_ready === 1'b1) begin
        sb.push_back(model(stim[idx]));
        n_acc++;
        idx++;
      end
      @(posedge clk); #1;
      if (idx < int'(stim.size())) in_data = stim[idx];
      g++;
    end
    in_valid = 1'b0;
    checks++;
    if (idx < int'(stim.size())) $display("FAIL send_timeout: got %0d beats expected %0d", idx, stim.size());
    else passes++;
  endtask

  task automatic wait_drain();
    int g = 0;
    while (n_del != n_acc && g < 200) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk); #1;
    checks++;
    if (n_del != n_acc || sb.size() != 0)
      $display("FAIL drain: got delivered=%0d queued=%0d expected delivered=%0d queued=0", n_del, sb.size(), n_acc);
    else passes++;
  endtask

  task automatic clr_cnt();
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
  endtask

  task automatic do_cfg(input logic [1:0] md, input logic [DW-1:0] th, input logic [DW-1:0] cp,
                        input logic [2:0] sh);
    int g = 0;
    cfg_we = 1'b1; cfg_mode = md; cfg_thr = th; cfg_cap = cp; cfg_shift = sh;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    checks++;
    if (cfg_pending !== 1'b1) $display("FAIL cfg_pending_set: got %b expected 1", cfg_pending);
    else passes++;
    while (cfg_pending === 1'b1 && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    checks++;
    if (cfg_pending !== 1'b0) $display("FAIL cfg_apply_timeout: got %b expected 0", cfg_pending);
    else passes++;
    m_mode = md; m_thr = th; m_cap = cp; m_shift = sh;
  endtask

  task automatic check_val(input string name, input logic [BW-1:0] got, input logic [BW-1:0] want);
    checks++;
    if (got !== want) $display("FAIL %s: got %h expected %h", name, got, want);
    else passes++;
  endtask

  task automatic test_reset();
    #12;
    check_val("rst_out_valid", BW'(out_valid), '0);
    check_val("rst_busy", BW'(busy), '0);
    check_val("rst_out_data", out_data, '0);
    check_val("rst_zero_cnt", BW'(zero_cnt), '0);
    check_val("rst_cfg_pending", BW'(cfg_pending), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("rst_in_ready", BW'(in_ready), BW'(1));
    stim.delete();
    stim.push_back(32'h090A00FF);
    send_beats();
    check_val("latency_n1_valid", BW'(out_valid), '0);
    @(posedge clk); #1;
    check_val("latency_n2_valid", BW'(out_valid), BW'(1));
    check_val("default_thresh_data", out_data, 32'h000A00FF);
    wait_drain();
    check_val("default_zero_cnt", BW'(zero_cnt), BW'(2));
  endtask

  task automatic test_back_to_back();
    logic done = 1'b0;
    logic [3:0] pat = 4'b1001;
    int base = n_del;
    stim.delete();
    for (int i = 0; i < 8; i++)
      stim.push_back({8'(8 * i + 3), 8'(i), 8'(8'h40 + i), 8'(8'hF0 - i)});
    fork
      begin send_beats(); done = 1'b1; end
      begin
        int k = 0;
        while (!done) begin
          out_ready = pat[k % 4];
          k++;
          @(posedge clk); #1;
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();
    check_val("b2b_count", BW'(n_del - base), BW'(8));
  endtask

  task automatic test_clamp();
    clr_cnt();
    do_cfg(2'd2, 8'h10, 8'h80, 3'd1);
    stim.delete();
    stim.push_back(32'h0F108081);
    send_beats();
    wait_drain();
    check_val("clamp_data", mon_last, 32'h00108080);
    check_val("clamp_zero_cnt", BW'(zero_cnt), BW'(1));
  endtask

  task automatic test_leaky();
    do_cfg(2'd3, 8'h40, 8'hFF, 3'd2);
    stim.delete();
    stim.push_back(32'h3C01407F);
    send_beats();
    wait_drain();
    check_val("leaky_data", mon_last, 32'h0F00407F);
    check_val("leaky_zero_cnt", BW'(zero_cnt), BW'(1));
  endtask

  task automatic test_cfg_busy();
    int g = 0;
    do_cfg(2'd1, 8'h0A, 8'hFF, 3'd1);
    out_ready = 1'b0;
    stim.delete();
    stim.push_back(32'h05050505);
    stim.push_back(32'h0A0B0C0D);
    send_beats();
    cfg_we = 1'b1; cfg_mode = 2'd0; cfg_thr = 8'h0A; cfg_cap = 8'hFF; cfg_shift = 3'd1;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    check_val("busy_cfg_pending", BW'(cfg_pending), BW'(1));
    check_val("busy_in_ready", BW'(in_ready), '0);
    out_ready = 1'b1;
    while (cfg_pending === 1'b1 && g < 50) begin
      check_val("pending_in_ready", BW'(in_ready), '0);
      @(posedge clk); #1;
      g++;
    end
    check_val("apply_done", BW'(cfg_pending), '0);
    check_val("apply_idle", BW'(busy), '0);
    check_val("apply_after_drain", BW'(n_acc - n_del), '0);
    m_mode = 2'd0;
    stim.delete();
    stim.push_back(32'h05050505);
    send_beats();
    wait_drain();
    check_val("pass_data", mon_last, 32'h05050505);
  endtask

  task automatic test_counter();
    int g = 0;
    do_cfg(2'd1, 8'h0A, 8'hFF, 3'd1);
    clr_cnt();
    stim.delete();
    for (int i = 0; i < 5; i++) stim.push_back(32'h00010203);
    send_beats();
    wait_drain();
    check_val("cnt_saturate", BW'(zero_cnt), BW'(15));
    stim.delete();
    stim.push_back(32'h00000000);
    send_beats();
    while (out_valid !== 1'b1 && g < 10) begin
      @(posedge clk); #1;
      g++;
    end
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    check_val("cnt_clr_hs", BW'(zero_cnt), '0);
    check_val("cnt_clr_hs_consumed", BW'(out_valid), '0);
  endtask

  task automatic test_reset_midstream();
    do_cfg(2'd2, 8'h10, 8'h80, 3'd1);
    stim.delete();
    stim.push_back(32'h00000000);
    send_beats();
    wait_drain();
    check_val("pre_rst_cnt", BW'(zero_cnt), BW'(4));
    out_ready = 1'b0;
    stim.delete();
    stim.push_back(32'h11111111);
    stim.push_back(32'h22222222);
    send_beats();
    check_val("pre_rst_valid", BW'(out_valid), BW'(1));
    #3;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_valid", BW'(out_valid), '0);
    check_val("mid_rst_busy", BW'(busy), '0);
    check_val("mid_rst_cnt", BW'(zero_cnt), '0);
    check_val("mid_rst_data", out_data, '0);
    sb.delete();
    n_acc = 0;
    n_del = 0;
    m_mode = 2'd1; m_thr = 8'h0A; m_cap = 8'hFF; m_shift = 3'd1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    stim.delete();
    stim.push_back(32'h090A00FF);
    send_beats();
    wait_drain();
    check_val("post_rst_default", mon_last, 32'h000A00FF);
    check_val("post_rst_cnt", BW'(zero_cnt), BW'(2));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_clamp();
    test_leaky();
    test_cfg_busy();
    test_counter();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
